// File: rtl/wb_commit_unit_pkg.sv
// Shared core constants and types for the writeback/commit unit.
package wb_commit_unit_pkg;
    localparam int LW_DEF  = 5;
    localparam int PW_DEF  = 6;
    localparam int CW_DEF  = 2;
    localparam int RNW_DEF = 2;
    localparam int CNT_W   = 32;

    typedef struct packed {
        logic srat_1en;
        logic arfen;
        logic write;
        logic br_right_en;
        logic raddren;
    } slot_en_t;
endpackage

// File: rtl/wb_slot_enable.sv
// Combinational commit enables for one slot of the commit group.
module wb_slot_enable
    import wb_commit_unit_pkg::*;
#(
    parameter int CW   = CW_DEF,
    parameter int RNW  = RNW_DEF,
    parameter int LW   = LW_DEF,
    parameter int PW   = PW_DEF,
    parameter int SLOT = 0
) (
    input  logic [CW-1:0]     ev,
    input  logic [CW-1:0]     rd_en,
    input  logic [CW*LW-1:0]  rd_l,
    input  logic              memwen,
    input  logic              btype,
    input  logic              pre_right,
    input  logic              real_dir,
    input  logic [PW-1:0]     rd_p,
    input  logic [PW-1:0]     rd_ps,
    input  logic [RNW-1:0]    rn_rd_en,
    input  logic [RNW*LW-1:0] rn_rd_l,
    output slot_en_t          en
);
    logic [LW-1:0] my_l;
    logic          rn_hit;
    logic          young_hit;

    always_comb begin
        en        = '0;
        my_l      = rd_l[SLOT*LW +: LW];
        rn_hit    = 1'b0;
        young_hit = 1'b0;
        for (int r = 0; r < RNW; r++) begin
            if (rn_rd_en[r] && (rn_rd_l[r*LW +: LW] == my_l)) rn_hit = 1'b1;
        end
        // A younger committing writer of the same register owns the final mapping.
        for (int j = 0; j < CW; j++) begin
            if ((j > SLOT) && ev[j] && rd_en[j] && (rd_l[j*LW +: LW] == my_l)) young_hit = 1'b1;
        end
        en.arfen       = ev[SLOT] & rd_en[SLOT];
        en.write       = ev[SLOT] & memwen;
        en.br_right_en = ev[SLOT] & btype & ~pre_right;
        en.raddren     = ev[SLOT] & btype & real_dir;
        en.srat_1en    = en.arfen & (rd_ps == rd_p) & ~rn_hit & ~young_hit;
    end
endmodule

// File: rtl/wb_commit_unit.sv
// Commit-group register: squash masking, per-slot enables, handshake, flush and commit counter.
module wb_commit_unit
    import wb_commit_unit_pkg::*;
#(
    parameter int CW  = CW_DEF,
    parameter int RNW = RNW_DEF,
    parameter int LW  = LW_DEF,
    parameter int PW  = PW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     in_valid,
    input  logic [CW-1:0]     in_rd_en,
    input  logic [CW*LW-1:0]  in_rd_l,
    input  logic [CW*PW-1:0]  in_rd_p,
    input  logic [CW*PW-1:0]  in_rd_ps,
    input  logic [CW-1:0]     in_memwen,
    input  logic [CW-1:0]     in_btype,
    input  logic [CW-1:0]     in_pre_right,
    input  logic [CW-1:0]     in_real_dir,
    input  logic [RNW-1:0]    rn_rd_en,
    input  logic [RNW*LW-1:0] rn_rd_l,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     srat_1en,
    output logic [CW-1:0]     arfen,
    output logic [CW-1:0]     write,
    output logic [CW-1:0]     br_right_en,
    output logic [CW-1:0]     raddren,
    output logic [CW*LW-1:0]  out_rd_l,
    output logic [CW*PW-1:0]  out_rd_p,
    output logic              flush,
    output logic [CNT_W-1:0]  commit_cnt
);
    logic [CW-1:0]    mp;
    logic [CW-1:0]    ev;
    slot_en_t         en_c [CW];
    logic [CW-1:0]    srat_c, arf_c, wr_c, br_c, ra_c;
    logic             accept;
    logic [CW-1:0]    ev_q;
    logic [CNT_W-1:0] cnt_q;

    assign in_ready   = (~out_valid | out_ready) & ~flush;
    assign accept     = (|in_valid) & in_ready;
    assign commit_cnt = cnt_q;

    // Any older mispredict kills the slot.
    always_comb begin
        mp = in_valid & in_btype & ~in_pre_right;
        ev = '0;
        for (int k = 0; k < CW; k++) begin
            ev[k] = in_valid[k];
            for (int m = 0; m < k; m++) begin
                if (mp[m]) ev[k] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < CW; g++) begin : g_slot
        wb_slot_enable #(
            .CW(CW), .RNW(RNW), .LW(LW), .PW(PW), .SLOT(g)
        ) u_slot_enable (
            .ev        (ev),
            .rd_en     (in_rd_en),
            .rd_l      (in_rd_l),
            .memwen    (in_memwen[g]),
            .btype     (in_btype[g]),
            .pre_right (in_pre_right[g]),
            .real_dir  (in_real_dir[g]),
            .rd_p      (in_rd_p[g*PW +: PW]),
            .rd_ps     (in_rd_ps[g*PW +: PW]),
            .rn_rd_en  (rn_rd_en),
            .rn_rd_l   (rn_rd_l),
            .en        (en_c[g])
        );
    end

    always_comb begin
        srat_c = '0;
        arf_c  = '0;
        wr_c   = '0;
        br_c   = '0;
        ra_c   = '0;
        for (int i = 0; i < CW; i++) begin
            srat_c[i] = en_c[i].srat_1en;
            arf_c[i]  = en_c[i].arfen;
            wr_c[i]   = en_c[i].write;
            br_c[i]   = en_c[i].br_right_en;
            ra_c[i]   = en_c[i].raddren;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            flush       <= 1'b0;
            ev_q        <= '0;
            srat_1en    <= '0;
            arfen       <= '0;
            write       <= '0;
            br_right_en <= '0;
            raddren     <= '0;
            out_rd_l    <= '0;
            out_rd_p    <= '0;
            cnt_q       <= '0;
        end else begin
            flush <= accept & (|mp);
            if (accept) begin
                out_valid   <= 1'b1;
                ev_q        <= ev;
                srat_1en    <= srat_c;
                arfen       <= arf_c;
                write       <= wr_c;
                br_right_en <= br_c;
                raddren     <= ra_c;
                out_rd_l    <= in_rd_l;
                out_rd_p    <= in_rd_p;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) cnt_q <= cnt_q + CNT_W'($countones(ev_q));
        end
    end
endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: directed scenarios plus randomized groups vs a reference model.
module tb_wb_commit_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid, in_rd_en, in_memwen, in_btype, in_pre_right, in_real_dir, rn_rd_en;
    logic [9:0]  in_rd_l, rn_rd_l;
    logic [11:0] in_rd_p, in_rd_ps;
    logic        in_ready, out_valid, out_ready, flush;
    logic [1:0]  srat_1en, arfen, write, br_right_en, raddren;
    logic [9:0]  out_rd_l;
    logic [11:0] out_rd_p;
    logic [31:0] commit_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [1:0] srat, arf, wr, br, ra;
        logic       sq;
        logic [1:0] n;
    } exp_t;

    wb_commit_unit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_rd_en(in_rd_en), .in_rd_l(in_rd_l),
        .in_rd_p(in_rd_p), .in_rd_ps(in_rd_ps), .in_memwen(in_memwen),
        .in_btype(in_btype), .in_pre_right(in_pre_right), .in_real_dir(in_real_dir),
        .rn_rd_en(rn_rd_en), .rn_rd_l(rn_rd_l),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .srat_1en(srat_1en), .arfen(arfen), .write(write),
        .br_right_en(br_right_en), .raddren(raddren),
        .out_rd_l(out_rd_l), .out_rd_p(out_rd_p),
        .flush(flush), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = '0; in_rd_en = '0; in_memwen = '0; in_btype = '0;
        in_pre_right = '0; in_real_dir = '0; rn_rd_en = '0;
        in_rd_l = '0; rn_rd_l = '0; in_rd_p = '0; in_rd_ps = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Slots after the first mispredicting branch are dead; everything else follows from the live set.
    function automatic exp_t model();
        exp_t e;
        int sp;
        int cnt;
        logic [1:0] live;
        logic blocked;
        e = '0;
        sp = 2;
        cnt = 0;
        live = '0;
        for (int k = 0; k < 2; k++)
            if (sp == 2 && in_valid[k] && in_btype[k] && !in_pre_right[k]) sp = k;
        for (int i = 0; i < 2; i++) begin
            live[i] = in_valid[i] && (i <= sp);
            if (live[i]) cnt++;
        end
        for (int i = 0; i < 2; i++) begin
            e.arf[i] = live[i] && in_rd_en[i];
            e.wr[i]  = live[i] && in_memwen[i];
            e.br[i]  = live[i] && in_btype[i] && !in_pre_right[i];
            e.ra[i]  = live[i] && in_btype[i] && in_real_dir[i];
            blocked = 1'b0;
            for (int r = 0; r < 2; r++)
                if (rn_rd_en[r] && rn_rd_l[r*5 +: 5] == in_rd_l[i*5 +: 5]) blocked = 1'b1;
            for (int j = i + 1; j < 2; j++)
                if (live[j] && in_rd_en[j] && in_rd_l[j*5 +: 5] == in_rd_l[i*5 +: 5]) blocked = 1'b1;
            e.srat[i] = e.arf[i] && (in_rd_ps[i*6 +: 6] == in_rd_p[i*6 +: 6]) && !blocked;
        end
        e.sq = (sp < 2);
        e.n = 2'(cnt);
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        idle();
        out_ready = 1'b0;
        tick();
        in_valid = 2'b11; in_rd_en = 2'b11;
        tick();
        idle();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (commit_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_commit_cnt: got %0d want 0", commit_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({flush, arfen, srat_1en, out_rd_l, out_rd_p} !== 27'd0) begin
            n_fail++; $display("FAIL reset_regs: got %h want 0", {flush, arfen, srat_1en, out_rd_l, out_rd_p});
        end
    endtask

    task automatic test_enable();
        do_reset();
        out_ready = 1'b1;
        in_valid = 2'b11; in_rd_en = 2'b11;
        in_rd_l = {5'd3, 5'd3};
        in_rd_p = {6'd10, 6'd9}; in_rd_ps = {6'd10, 6'd9};
        tick();
        idle();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL enable_valid: got %b want 1", out_valid); end
        n_cmp++; if (srat_1en !== 2'b10) begin n_fail++; $display("FAIL enable_srat: got %b want 10", srat_1en); end
        n_cmp++; if (arfen !== 2'b11) begin n_fail++; $display("FAIL enable_arfen: got %b want 11", arfen); end
        n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL enable_flush: got %b want 0", flush); end
        n_cmp++; if ({out_rd_l, out_rd_p} !== {5'd3, 5'd3, 6'd10, 6'd9}) begin
            n_fail++; $display("FAIL enable_idx: got %h want %h", {out_rd_l, out_rd_p}, {5'd3, 5'd3, 6'd10, 6'd9});
        end
        tick();
        n_cmp++; if (commit_cnt !== 32'd2) begin n_fail++; $display("FAIL enable_cnt: got %0d want 2", commit_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL enable_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_squash();
        do_reset();
        out_ready = 1'b1;
        in_valid = 2'b11; in_btype = 2'b01; in_pre_right = 2'b00;
        in_real_dir = 2'b01; in_memwen = 2'b10;
        tick();
        n_cmp++; if ({br_right_en, raddren, write} !== 6'b01_01_00) begin
            n_fail++; $display("FAIL squash_enables: got %b want 010100", {br_right_en, raddren, write});
        end
        n_cmp++; if (flush !== 1'b1) begin n_fail++; $display("FAIL squash_flush: got %b want 1", flush); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL squash_ready: got %b want 0", in_ready); end
        idle();
        in_valid = 2'b11; in_rd_en = 2'b11; in_memwen = 2'b11;
        tick();
        idle();
        n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL squash_flush_end: got %b want 0", flush); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL squash_dropped: got %b want 0", out_valid); end
        n_cmp++; if (commit_cnt !== 32'd1) begin n_fail++; $display("FAIL squash_cnt: got %0d want 1", commit_cnt); end
        tick();
        n_cmp++; if (commit_cnt !== 32'd1) begin n_fail++; $display("FAIL squash_cnt_after: got %0d want 1", commit_cnt); end
    endtask

    task automatic test_stall();
        logic [31:0] want;
        do_reset();
        out_ready = 1'b0;
        in_valid = 2'b11; in_rd_en = 2'b11; in_memwen = 2'b01;
        in_rd_l = {5'd5, 5'd4};
        in_rd_p = {6'd20, 6'd21}; in_rd_ps = {6'd20, 6'd21};
        want = {2'b11, 2'b11, 2'b01, 5'd5, 5'd4, 6'd20, 6'd21};
        tick();
        in_valid = 2'b01; in_rd_en = 2'b01; in_memwen = 2'b00; in_rd_l = {5'd9, 5'd9};
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_hs c%0d: got valid=%b ready=%b want 1 0", c, out_valid, in_ready);
            end
            n_cmp++; if ({srat_1en, arfen, write, out_rd_l, out_rd_p} !== want) begin
                n_fail++; $display("FAIL stall_hold c%0d: got %h want %h", c, {srat_1en, arfen, write, out_rd_l, out_rd_p}, want);
            end
            tick();
        end
        idle();
        out_ready = 1'b1;
        tick();
        n_cmp++; if (commit_cnt !== 32'd2) begin n_fail++; $display("FAIL stall_cnt: got %0d want 2", commit_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_rename_hit();
        // {rn_rd_en, rn_l1, rn_l0, rd_l0, rd_ps0, want_srat0}
        logic [24:0] tbl [4];
        tbl[0] = {2'b01, 5'd7, 5'd7, 5'd7, 6'd12, 1'b0, 1'b0};
        tbl[1] = {2'b10, 5'd9, 5'd7, 5'd7, 6'd12, 1'b1, 1'b0};
        tbl[2] = {2'b00, 5'd7, 5'd7, 5'd7, 6'd13, 1'b0, 1'b0};
        tbl[3] = {2'b01, 5'd3, 5'd0, 5'd0, 6'd12, 1'b0, 1'b0};
        do_reset();
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            idle();
            in_valid = 2'b01; in_rd_en = 2'b01;
            rn_rd_en = tbl[t][24:23];
            rn_rd_l  = tbl[t][22:13];
            in_rd_l  = {5'd0, tbl[t][12:8]};
            in_rd_p  = {6'd0, 6'd12};
            in_rd_ps = {6'd0, tbl[t][7:2]};
            tick();
            n_cmp++; if ({srat_1en[0], arfen[0]} !== {tbl[t][1], 1'b1}) begin
                n_fail++; $display("FAIL rename_hit t%0d: got srat=%b arf=%b want srat=%b arf=1", t, srat_1en[0], arfen[0], tbl[t][1]);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        out_ready = 1'b1;
        in_valid = 2'b11;
        tick();
        idle();
        n_cmp++; if (commit_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preset: got %h want ffffffff", commit_cnt); end
        tick();
        n_cmp++; if (commit_cnt !== 32'd1) begin n_fail++; $display("FAIL wrap_cnt: got %h want 00000001", commit_cnt); end
    endtask

    task automatic test_random();
        exp_t        e;
        logic        m_valid, m_flush, exp_ready, acc;
        logic [1:0]  m_n;
        logic [31:0] m_cnt, m_out;
        do_reset();
        m_valid = 1'b0; m_flush = 1'b0; m_cnt = '0; m_n = '0; m_out = '0;
        for (int c = 0; c < 400; c++) begin
            in_valid     = 2'($urandom_range(0, 3));
            in_rd_en     = 2'($urandom_range(0, 3));
            in_memwen    = 2'($urandom_range(0, 3));
            in_btype     = 2'($urandom_range(0, 3));
            in_pre_right = 2'($urandom_range(0, 3));
            in_real_dir  = 2'($urandom_range(0, 3));
            rn_rd_en     = 2'($urandom_range(0, 3));
            in_rd_l      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            rn_rd_l      = {5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))};
            in_rd_p      = 12'($urandom);
            for (int i = 0; i < 2; i++)
                in_rd_ps[i*6 +: 6] = ($urandom_range(0, 9) < 6) ? in_rd_p[i*6 +: 6] : 6'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = (!m_valid || out_ready) && !m_flush;
            n_cmp++; if (in_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, in_ready, exp_ready);
            end
            e = model();
            acc = (in_valid != 2'b00) && exp_ready;
            if (m_valid && out_ready) m_cnt = m_cnt + 32'(m_n);
            m_flush = acc && e.sq;
            if (acc) begin
                m_valid = 1'b1;
                m_n = e.n;
                m_out = {e.srat, e.arf, e.wr, e.br, e.ra, in_rd_l, in_rd_p} ;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            tick();
            n_cmp++; if ({out_valid, flush} !== {m_valid, m_flush}) begin
                n_fail++; $display("FAIL rand_state c%0d: got valid=%b flush=%b want %b %b", c, out_valid, flush, m_valid, m_flush);
            end
            n_cmp++; if (commit_cnt !== m_cnt) begin
                n_fail++; $display("FAIL rand_cnt c%0d: got %0d want %0d", c, commit_cnt, m_cnt);
            end
            if (m_valid) begin
                n_cmp++; if ({srat_1en, arfen, write, br_right_en, raddren, out_rd_l, out_rd_p} !== {m_out[31:22], m_out[21:0]}) begin
                    n_fail++; $display("FAIL rand_group c%0d: got %h want %h", c,
                        {srat_1en, arfen, write, br_right_en, raddren, out_rd_l, out_rd_p}, m_out);
                end
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        idle();
        test_reset();
        test_enable();
        test_squash();
        test_stall();
        test_rename_hit();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
